// File: rtl/load_align_ctrl.sv
// load_align_ctrl
//   Load sequencer between the load/store stage and a 32-bit AXI4-lite read
//   port. One RV64 load of any size and byte alignment becomes 1..3 aligned
//   32-bit reads, issued one at a time. The beats are merged, shifted to the
//   access offset, masked to the access size and sign/zero-extended to XLEN.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   req_valid/req_ready       load request handshake (ready only in IDLE)
//   req_addr, req_funct3      byte address and RISC-V load funct3
//   resp_valid/resp_ready     result handshake
//   resp_data, resp_err       extended load result, bus error / illegal funct3
//   araddr/arvalid/arready    AXI4-lite AR channel (araddr 4-byte aligned)
//   arprot                    constant 3'b000
//   rdata/rresp/rvalid/rready AXI4-lite R channel
module load_align_ctrl #(
  parameter int XLEN      = 64,
  parameter int MAX_BEATS = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_addr,
  input  logic [2:0]      req_funct3,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic            resp_err,
  output logic [XLEN-1:0] araddr,
  output logic            arvalid,
  input  logic            arready,
  output logic [2:0]      arprot,
  input  logic [31:0]     rdata,
  input  logic [1:0]      rresp,
  input  logic            rvalid,
  output logic            rready
);

  localparam int BUF_W = 32 * MAX_BEATS;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t          state;
  logic [1:0]      off_q;
  logic [2:0]      f3_q;
  logic [XLEN-1:0] base_q;
  logic [1:0]      beat_q;
  logic [1:0]      nbeats_q;
  logic [31:0]     beat_buf [MAX_BEATS];
  logic [BUF_W-1:0] merged;

  logic [3:0] req_size;
  logic [3:0] req_span;

  assign arprot   = 3'b000;
  assign req_size = 4'd1 << req_funct3[1:0];
  // Bytes touched from the aligned base, rounded up to whole 32-bit beats.
  assign req_span = {2'b00, req_addr[1:0]} + req_size + 4'd3;

  // Beat buffer as seen on the final R handshake: the beat arriving this
  // cycle replaces its slot so the result can be registered in the same edge.
  always_comb begin
    merged = '0;
    for (int i = 0; i < MAX_BEATS; i++) begin
      merged[32*i +: 32] = (beat_q == 2'(i)) ? rdata : beat_buf[i];
    end
  end

  function automatic logic [XLEN-1:0] load_extract(input logic [BUF_W-1:0] raw,
                                                   input logic [1:0]       off,
                                                   input logic [2:0]       f3);
    logic [BUF_W-1:0]   s;
    logic signed [7:0]  b8;
    logic signed [15:0] h16;
    logic signed [31:0] w32;
    logic [XLEN-1:0]    r;
    s   = raw >> {off, 3'b000};
    b8  = s[7:0];
    h16 = s[15:0];
    w32 = s[31:0];
    r   = '0;
    case (f3[1:0])
      2'd0:    r = f3[2] ? XLEN'(s[7:0])  : XLEN'(b8);
      2'd1:    r = f3[2] ? XLEN'(s[15:0]) : XLEN'(h16);
      2'd2:    r = f3[2] ? XLEN'(s[31:0]) : XLEN'(w32);
      default: r = XLEN'(s[63:0]);
    endcase
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
      arvalid    <= 1'b0;
      rready     <= 1'b0;
      araddr     <= '0;
      beat_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!req_ready) begin
            req_ready <= 1'b1;
          end else if (req_valid) begin
            req_ready <= 1'b0;
            off_q     <= req_addr[1:0];
            f3_q      <= req_funct3;
            base_q    <= {req_addr[XLEN-1:2], 2'b00};
            nbeats_q  <= req_span[3:2];
            beat_q    <= '0;
            resp_err  <= 1'b0;
            if (req_funct3 == 3'b111) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_data  <= '0;
            end else begin
              state   <= ADDR;
              arvalid <= 1'b1;
              araddr  <= {req_addr[XLEN-1:2], 2'b00};
            end
          end
        end
        ADDR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= DATA;
          end
        end
        DATA: begin
          if (rvalid) begin
            beat_buf[beat_q] <= rdata;
            beat_q           <= beat_q + 2'd1;
            rready           <= 1'b0;
            if (rresp != 2'b00) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_data  <= '0;
            end else if ((beat_q + 2'd1) < nbeats_q) begin
              state   <= ADDR;
              arvalid <= 1'b1;
              araddr  <= base_q + XLEN'({beat_q + 2'd1, 2'b00});
            end else begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_data  <= load_extract(merged, off_q, f3_q);
            end
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_align_ctrl.sv
module tb_load_align_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [63:0] req_addr = '0;
  logic [2:0]  req_funct3 = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [63:0] resp_data;
  logic        resp_err;
  logic [63:0] araddr;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [2:0]  arprot;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic        rvalid = 1'b0;
  logic        rready;

  int checks = 0;
  int errors = 0;

  // responder state
  int          ar_wait = 0;
  int          r_wait = 0;
  int          err_beat = 0;
  int          ar_cnt = 0;
  logic [63:0] ar_q[$];
  logic        pending = 1'b0;
  logic [63:0] pend_addr = '0;
  logic        ar_prev = 1'b0;
  logic [63:0] prev_addr = '0;

  load_align_ctrl #(.XLEN(64), .MAX_BEATS(3)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_funct3(req_funct3),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_err(resp_err),
    .araddr(araddr), .arvalid(arvalid), .arready(arready), .arprot(arprot),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem(input logic [63:0] a);
    case (a)
      64'h30:  return 32'h8A8FC3C7;
      64'h34:  return 32'h017F423C;
      64'h38:  return 32'h66778899;
      default: return 32'hDEADBEEF;
    endcase
  endfunction

  // Zero-wait AXI4-lite responder with optional stalls and an injected SLVERR.
  always @(negedge clk) begin
    if (rst) begin
      arready = 1'b0;
      rvalid  = 1'b0;
      pending = 1'b0;
      ar_prev = 1'b0;
    end else begin
      if (arvalid) begin
        if (ar_prev) check("araddr_stable", araddr, prev_addr);
        if (ar_wait > 0) begin
          arready   = 1'b0;
          ar_wait   = ar_wait - 1;
          ar_prev   = 1'b1;
          prev_addr = araddr;
        end else begin
          arready = 1'b1;
          ar_q.push_back(araddr);
          pend_addr = araddr;
          pending   = 1'b1;
          ar_cnt    = ar_cnt + 1;
          ar_prev   = 1'b0;
        end
      end else begin
        arready = 1'b0;
        ar_prev = 1'b0;
      end
      if (rvalid) begin
        rvalid = 1'b0;
      end else if (rready && pending) begin
        if (r_wait > 0) begin
          r_wait = r_wait - 1;
        end else begin
          rvalid  = 1'b1;
          rdata   = mem(pend_addr);
          rresp   = (ar_cnt == err_beat) ? 2'b10 : 2'b00;
          pending = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && arvalid && rready) begin
      errors++;
      $error("FAIL ar_r_overlap observed=arvalid&rready expected=exclusive");
    end
  end

  task automatic do_load(input string tag, input logic [63:0] addr, input logic [2:0] f3,
                         input logic [63:0] exp_data, input logic exp_err,
                         input int exp_nar, input int exp_lat, input int hold);
    int n;
    int lat;
    logic [63:0] base;
    base = {addr[63:2], 2'b00};
    ar_q.delete();
    ar_cnt = 0;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_req_ready"}, 64'(req_ready), 64'd1);
    req_valid  = 1'b1;
    req_addr   = addr;
    req_funct3 = f3;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_resp_valid"}, 64'(resp_valid), 64'd1);
    if (exp_lat > 0) check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_data"}, resp_data, exp_data);
    check({tag, "_err"}, 64'(resp_err), 64'(exp_err));
    check({tag, "_nar"}, 64'(ar_q.size()), 64'(exp_nar));
    for (int i = 0; i < exp_nar; i++) begin
      if (i < ar_q.size()) check({tag, "_araddr"}, ar_q[i], base + 64'(4 * i));
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, 64'(resp_valid), 64'd1);
      check({tag, "_hold_data"}, resp_data, exp_data);
      check({tag, "_hold_err"}, 64'(resp_err), 64'(exp_err));
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check({tag, "_resp_drop"}, 64'(resp_valid), 64'd0);
    check({tag, "_ready_back"}, 64'(req_ready), 64'd1);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_data", resp_data, 64'd0);
    check("rst_resp_err", 64'(resp_err), 64'd0);
    check("rst_arvalid", 64'(arvalid), 64'd0);
    check("rst_rready", 64'(rready), 64'd0);
    check("rst_araddr", araddr, 64'd0);
    check("rst_arprot", 64'(arprot), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    do_load("lb30",  64'h30, 3'b000, 64'hFFFFFFFF_FFFFFFC7, 1'b0, 1, 3, 0);
    do_load("lbu33", 64'h33, 3'b100, 64'h00000000_0000008A, 1'b0, 1, 3, 0);
    do_load("ld34",  64'h34, 3'b011, 64'h66778899_017F423C, 1'b0, 2, 5, 0);
    do_load("lw33",  64'h33, 3'b010, 64'h00000000_7F423C8A, 1'b0, 2, 5, 0);
    do_load("ld31",  64'h31, 3'b011, 64'h99017F42_3C8A8FC3, 1'b0, 3, 7, 0);
    do_load("lh36",  64'h36, 3'b001, 64'h00000000_0000017F, 1'b0, 1, 3, 0);
    do_load("lh32",  64'h32, 3'b001, 64'hFFFFFFFF_FFFF8A8F, 1'b0, 1, 3, 0);
    do_load("lhu32", 64'h32, 3'b101, 64'h00000000_00008A8F, 1'b0, 1, 3, 0);
    do_load("lwu30", 64'h30, 3'b110, 64'h00000000_8A8FC3C7, 1'b0, 1, 3, 0);

    ar_wait = 5;
    r_wait  = 3;
    do_load("lw33_stall", 64'h33, 3'b010, 64'h00000000_7F423C8A, 1'b0, 2, -1, 0);
    do_load("ld34_hold",  64'h34, 3'b011, 64'h66778899_017F423C, 1'b0, 2, 5, 4);

    err_beat = 2;
    do_load("ld31_slverr", 64'h31, 3'b011, 64'h0, 1'b1, 2, -1, 0);
    err_beat = 0;
    do_load("illegal", 64'h30, 3'b111, 64'h0, 1'b1, 0, 1, 0);

    // reset while the AR is held off
    ar_wait = 1000;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    req_valid  = 1'b1;
    req_addr   = 64'h31;
    req_funct3 = 3'b011;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("mid_arvalid", 64'(arvalid), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_arvalid", 64'(arvalid), 64'd0);
    check("mid_rst_resp_valid", 64'(resp_valid), 64'd0);
    rst = 1'b0;
    ar_wait = 0;
    @(negedge clk);
    check("post_rst_req_ready", 64'(req_ready), 64'd1);
    check("post_rst_resp_valid", 64'(resp_valid), 64'd0);
    do_load("lb30_after_rst", 64'h30, 3'b000, 64'hFFFFFFFF_FFFFFFC7, 1'b0, 1, 3, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
